// File: rtl/lfsr_checker_pkg.sv
// Shared pattern definitions for the LFSR checker and its matching generator:
// state encodings, register word addresses and a saturating-increment helper.
package lfsr_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_STATUS   = 3'd1;
    localparam logic [2:0] ADDR_LENGTH   = 3'd2;
    localparam logic [2:0] ADDR_WCOUNT   = 3'd3;
    localparam logic [2:0] ADDR_ECOUNT   = 3'd4;
    localparam logic [2:0] ADDR_FIRSTERR = 3'd5;

    localparam int LFSR_W = 15;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

endpackage

// File: rtl/lfsr_checker_lfsr15.sv
// 15-bit Fibonacci LFSR (x^15 + x^14 + 1) shared by pattern generator and checker;
// the low DataBits of the register form the current pattern word.
module lfsr15_shift #(
    parameter int          DataBits = 8,
    parameter logic [14:0] LfsrSeed = 15'd1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_init,
    input  logic                i_shift,
    output logic [DataBits-1:0] o_data
);

    logic [14:0] r_lfsr;

    // LFSR state: reload seed on init, otherwise advance one step per shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= LfsrSeed;
        end else if (i_init) begin
            r_lfsr <= LfsrSeed;
        end else if (i_shift) begin
            r_lfsr <= {r_lfsr[13:0], r_lfsr[14] ^ r_lfsr[13]};
        end else begin
            r_lfsr <= r_lfsr;
        end
    end

    assign o_data = r_lfsr[DataBits-1:0];

endmodule

// File: rtl/lfsr_checker.sv
// APB-configured stream checker: compares incoming words against an LFSR
// pattern and keeps word/error counts and the index of the first mismatch.
module lfsr_checker
    import lfsr_checker_pkg::*;
#(
    parameter int Seed     = 1,
    parameter int DataBits = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          cfg_paddr,
    input  logic                cfg_pwrite,
    input  logic [31:0]         cfg_pwdata,
    input  logic                cfg_psel,
    input  logic                cfg_penable,
    output logic                cfg_pready,
    output logic [31:0]         cfg_prdata,
    output logic                cfg_pslverr,
    input  logic                din_valid,
    input  logic [DataBits-1:0] din_data,
    output logic                din_ready
);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [31:0]         r_len;
    logic [31:0]         r_wc;
    logic [31:0]         r_ec;
    logic [31:0]         r_fei;
    logic                r_flag;
    logic [31:0]         r_prdata;
    logic [31:0]         w_rdata;
    logic [31:0]         w_wc_inc;
    logic [DataBits-1:0] w_lfsr_data;
    logic [2:0]          w_waddr;
    logic                w_setup;
    logic                w_wr;
    logic                w_rd;
    logic                w_ctrl_wr;
    logic                w_start;
    logic                w_stop;
    logic                w_clear;
    logic                w_accept;
    logic                w_mismatch;
    logic                w_hit_len;
    logic                w_unused_addr;

    assign cfg_pready    = 1'b1;
    assign cfg_pslverr   = 1'b0;
    assign cfg_prdata    = r_prdata;
    assign w_unused_addr = ^cfg_paddr[1:0];

    assign w_waddr   = cfg_paddr[4:2];
    assign w_setup   = cfg_psel && !cfg_penable;
    assign w_wr      = w_setup && cfg_pwrite;
    assign w_rd      = w_setup && !cfg_pwrite;
    assign w_ctrl_wr = w_wr && (w_waddr == ADDR_CTRL);
    // Stop beats start when both bits arrive in one write.
    assign w_stop    = w_ctrl_wr && cfg_pwdata[1];
    assign w_start   = w_ctrl_wr && cfg_pwdata[0] && !cfg_pwdata[1];
    assign w_clear   = w_ctrl_wr && cfg_pwdata[2];

    assign din_ready  = (r_state == ST_RUN);
    assign w_accept   = din_valid && din_ready;
    assign w_mismatch = w_accept && (din_data != w_lfsr_data);
    assign w_wc_inc   = r_wc + 32'd1;
    assign w_hit_len  = w_accept && !w_clear && (r_len != 32'd0) && (w_wc_inc == r_len);

    lfsr15_shift #(
        .DataBits (DataBits),
        .LfsrSeed (15'(Seed))
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .i_init  (r_state == ST_ARM),
        .i_shift (w_accept),
        .o_data  (w_lfsr_data)
    );

    // Next-state decode: control writes override the normal sequencing.
    always_comb begin
        w_state_nxt = r_state;
        if (w_stop) begin
            w_state_nxt = ST_IDLE;
        end else if (w_start) begin
            w_state_nxt = ST_ARM;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_IDLE;
                ST_ARM:  w_state_nxt = ST_RUN;
                ST_RUN:  w_state_nxt = w_hit_len ? ST_DONE : ST_RUN;
                ST_DONE: w_state_nxt = ST_DONE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Word/error bookkeeping; start and clear zero everything, even over an accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wc   <= 32'd0;
            r_ec   <= 32'd0;
            r_fei  <= 32'd0;
            r_flag <= 1'b0;
        end else if (w_start || w_clear) begin
            r_wc   <= 32'd0;
            r_ec   <= 32'd0;
            r_fei  <= 32'd0;
            r_flag <= 1'b0;
        end else if (w_accept) begin
            r_wc <= w_wc_inc;
            if (w_mismatch) begin
                r_ec   <= sat_inc32(r_ec);
                r_flag <= 1'b1;
                r_fei  <= r_flag ? r_fei : r_wc;
            end
        end
    end

    // Length register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len <= 32'd0;
        end else if (w_wr && (w_waddr == ADDR_LENGTH)) begin
            r_len <= cfg_pwdata;
        end else begin
            r_len <= r_len;
        end
    end

    // Read-data mux; Status packs din_ready at bit 0 up to state at bits 4:3.
    always_comb begin
        w_rdata = 32'd0;
        case (w_waddr)
            ADDR_STATUS:   w_rdata = {27'd0, r_state, r_flag, din_valid, din_ready};
            ADDR_LENGTH:   w_rdata = r_len;
            ADDR_WCOUNT:   w_rdata = r_wc;
            ADDR_ECOUNT:   w_rdata = r_ec;
            ADDR_FIRSTERR: w_rdata = r_fei;
            default:       w_rdata = 32'd0;
        endcase
    end

    // Registered read data, captured in the setup cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prdata <= 32'd0;
        end else if (w_rd) begin
            r_prdata <= w_rdata;
        end else begin
            r_prdata <= r_prdata;
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed-sequence bench with randomized stream traffic for lfsr_checker.
module tb_lfsr_checker;

    localparam int DB   = 8;
    localparam int SEED = 32'h0000_35A1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  cfg_paddr = 5'd0;
    logic        cfg_pwrite = 1'b0;
    logic [31:0] cfg_pwdata = 32'd0;
    logic        cfg_psel = 1'b0;
    logic        cfg_penable = 1'b0;
    logic        cfg_pready;
    logic [31:0] cfg_prdata;
    logic        cfg_pslverr;
    logic        din_valid = 1'b0;
    logic [DB-1:0] din_data = '0;
    logic        din_ready;

    int checks = 0;
    int errors = 0;

    int unsigned m_lfsr, m_wc, m_ec, m_fei;
    bit          m_flag;

    lfsr_checker #(.Seed(SEED), .DataBits(DB)) dut (
        .clk(clk), .rst(rst),
        .cfg_paddr(cfg_paddr), .cfg_pwrite(cfg_pwrite), .cfg_pwdata(cfg_pwdata),
        .cfg_psel(cfg_psel), .cfg_penable(cfg_penable), .cfg_pready(cfg_pready),
        .cfg_prdata(cfg_prdata), .cfg_pslverr(cfg_pslverr),
        .din_valid(din_valid), .din_data(din_data), .din_ready(din_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // Pattern sequence: 15-bit shift-left with feedback bit14 xor bit13.
    function automatic int unsigned next_pat(input int unsigned v);
        return ((v * 2) % 32768) + (((v / 16384) ^ (v / 8192)) & 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apb_write(input logic [4:0] a, input logic [31:0] d);
        cfg_psel = 1'b1; cfg_penable = 1'b0; cfg_pwrite = 1'b1; cfg_paddr = a; cfg_pwdata = d;
        tick();
        cfg_penable = 1'b1;
        tick();
        cfg_psel = 1'b0; cfg_penable = 1'b0; cfg_pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [4:0] a, output logic [31:0] d);
        cfg_psel = 1'b1; cfg_penable = 1'b0; cfg_pwrite = 1'b0; cfg_paddr = a;
        tick();
        d = cfg_prdata;
        cfg_penable = 1'b1;
        tick();
        cfg_psel = 1'b0; cfg_penable = 1'b0;
    endtask

    task automatic model_zero();
        m_wc = 0; m_ec = 0; m_fei = 0; m_flag = 1'b0;
    endtask

    task automatic do_start();
        apb_write(5'd0, 32'd1);
        model_zero();
        m_lfsr = SEED;
    endtask

    task automatic model_accept(input int unsigned d);
        if (d != (m_lfsr % (1 << DB))) begin
            if (!m_flag) m_fei = m_wc;
            m_flag = 1'b1;
            if (m_ec != 32'hFFFF_FFFF) m_ec++;
        end
        m_wc++;
        m_lfsr = next_pat(m_lfsr);
    endtask

    task automatic stream(input int n, input int corrupt_idx, input bit rand_valid, input int err_pct);
        int got = 0;
        int budget = 0;
        int unsigned d;
        bit v;
        while (got < n && budget < 20 * n + 50) begin
            v = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            d = m_lfsr % (1 << DB);
            if (int'(m_wc) == corrupt_idx) d = d ^ 1;
            if (err_pct > 0 && $urandom_range(0, 99) < err_pct) d = $urandom_range(0, (1 << DB) - 1);
            din_valid = v;
            din_data  = d[DB-1:0];
            if (v && din_ready) begin
                model_accept(d);
                got++;
            end
            tick();
            budget++;
        end
        din_valid = 1'b0;
        check("stream_accepts", 32'(got), 32'(n));
    endtask

    task automatic check_regs(input string tag, input int st);
        logic [31:0] r;
        logic [31:0] e;
        e = (32'(st) << 3) | (32'(m_flag) << 2) | ((st == 2) ? 32'd1 : 32'd0);
        apb_read(5'd12, r); check({tag, "_wc"}, r, m_wc);
        apb_read(5'd16, r); check({tag, "_ec"}, r, m_ec);
        apb_read(5'd20, r); check({tag, "_fei"}, r, m_fei);
        apb_read(5'd4,  r); check({tag, "_status"}, r, e);
        check({tag, "_ready"}, 32'(din_ready), (st == 2) ? 32'd1 : 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        m_lfsr = SEED;
        model_zero();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // reset state
        check("rst_pready", 32'(cfg_pready), 32'd1);
        check("rst_pslverr", 32'(cfg_pslverr), 32'd0);
        check("rst_prdata", cfg_prdata, 32'd0);
        apb_read(5'd8, r); check("rst_len", r, 32'd0);
        check_regs("rst", 0);

        // Length=16, clean pattern, valid always high
        apb_write(5'd8, 32'd16);
        apb_read(5'd8, r); check("len_rw", r, 32'd16);
        do_start();
        stream(16, -1, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            din_valid = 1'b1;
            check("done_ready_low", 32'(din_ready), 32'd0);
            tick();
        end
        din_valid = 1'b0;
        check_regs("len16", 3);
        check("len16_wc_const", m_wc, 32'd16);

        // Length=16 with word 4 corrupted, restarted from DONE
        do_start();
        stream(16, 4, 1'b0, 0);
        check_regs("err4", 3);
        apb_read(5'd20, r); check("err4_fei_const", r, 32'd4);
        apb_read(5'd16, r); check("err4_ec_const", r, 32'd1);

        // unlimited length, 50% valid, 1000 words, then stop
        apb_write(5'd8, 32'd0);
        do_start();
        stream(1000, -1, 1'b1, 0);
        apb_write(5'd0, 32'd2);
        check_regs("free1000", 0);
        apb_read(5'd12, r); check("free1000_wc_const", r, 32'd1000);

        // random corrupted traffic
        do_start();
        stream(300, -1, 1'b1, 15);
        check_regs("randerr", 2);
        apb_write(5'd0, 32'd2);

        // clear coincides with an accept
        do_start();
        stream(3, -1, 1'b0, 0);
        check("clr_ready", 32'(din_ready), 32'd1);
        cfg_psel = 1'b1; cfg_penable = 1'b0; cfg_pwrite = 1'b1; cfg_paddr = 5'd0; cfg_pwdata = 32'd4;
        din_valid = 1'b1;
        din_data = DB'(m_lfsr % (1 << DB));
        tick();
        m_lfsr = next_pat(m_lfsr);
        model_zero();
        din_valid = 1'b0;
        cfg_penable = 1'b1;
        tick();
        cfg_psel = 1'b0; cfg_penable = 1'b0; cfg_pwrite = 1'b0;
        apb_read(5'd12, r); check("clr_wc_zero", r, 32'd0);
        stream(1, -1, 1'b0, 0);
        check_regs("clr_next", 2);

        // asynchronous reset mid-run
        do_start();
        stream(7, -1, 1'b0, 0);
        #3 rst = 1'b1;
        #1 check("arst_ready_async", 32'(din_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_zero();
        m_lfsr = SEED;
        repeat (5) tick();
        check_regs("arst", 0);
        apb_read(5'd8, r); check("arst_len", r, 32'd0);
        do_start();
        stream(10, -1, 1'b0, 0);
        check_regs("arst_restart", 2);

        // start+stop in RUN: stop wins, counters kept; unmapped addresses
        stream(5, -1, 1'b1, 0);
        apb_write(5'd0, 32'd3);
        check_regs("startstop", 0);
        apb_read(5'd28, r); check("addr7_zero", r, 32'd0);
        apb_write(5'd24, 32'hDEAD_BEEF);
        apb_read(5'd24, r); check("addr6_zero", r, 32'd0);
        apb_read(5'd8, r); check("len_kept", r, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
